// File: rtl/elevator_mgmt_pkg.sv
// Shared codes, state type, request indices and arbitration helpers for the
// BCD_management command transmitter.
package elevator_mgmt_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned REQ_W  = 6;
    localparam int unsigned GAP_W  = 4;

    localparam logic [CODE_W-1:0] CODE_NOP    = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_FLOOR1 = 4'b0001;
    localparam logic [CODE_W-1:0] CODE_FLOOR2 = 4'b0010;
    localparam logic [CODE_W-1:0] CODE_FLOOR3 = 4'b0011;
    localparam logic [CODE_W-1:0] CODE_STOP   = 4'b1011;
    localparam logic [CODE_W-1:0] CODE_HOLD   = 4'b1100;
    localparam logic [CODE_W-1:0] CODE_RESUME = 4'b1101;

    localparam int unsigned IDX_FLOOR1 = 0;
    localparam int unsigned IDX_FLOOR2 = 1;
    localparam int unsigned IDX_FLOOR3 = 2;
    localparam int unsigned IDX_HOLD   = 3;
    localparam int unsigned IDX_STOP   = 4;
    localparam int unsigned IDX_RESUME = 5;

    // Requests discarded when a STOP goes out: hold and all floor calls.
    localparam logic [REQ_W-1:0] STOP_FLUSH_MASK = 6'b001111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // One-hot winner: stop > resume > hold > floor1 > floor2 > floor3.
    function automatic logic [REQ_W-1:0] pick_grant(input logic [REQ_W-1:0] req);
        logic [REQ_W-1:0] g;
        g = '0;
        if (req[IDX_STOP])        g[IDX_STOP]   = 1'b1;
        else if (req[IDX_RESUME]) g[IDX_RESUME] = 1'b1;
        else if (req[IDX_HOLD])   g[IDX_HOLD]   = 1'b1;
        else if (req[IDX_FLOOR1]) g[IDX_FLOOR1] = 1'b1;
        else if (req[IDX_FLOOR2]) g[IDX_FLOOR2] = 1'b1;
        else if (req[IDX_FLOOR3]) g[IDX_FLOOR3] = 1'b1;
        return g;
    endfunction

    function automatic logic [CODE_W-1:0] grant_code(input logic [REQ_W-1:0] g);
        logic [CODE_W-1:0] c;
        c = CODE_NOP;
        if (g[IDX_STOP])        c = CODE_STOP;
        else if (g[IDX_RESUME]) c = CODE_RESUME;
        else if (g[IDX_HOLD])   c = CODE_HOLD;
        else if (g[IDX_FLOOR1]) c = CODE_FLOOR1;
        else if (g[IDX_FLOOR2]) c = CODE_FLOOR2;
        else if (g[IDX_FLOOR3]) c = CODE_FLOOR3;
        return c;
    endfunction

endpackage

// File: rtl/mgmt_edge_detect.sv
// Rising-edge detector; history resets to ones so buttons held through reset
// never fire on release.
module mgmt_edge_detect
    import elevator_mgmt_pkg::*;
#(
    parameter int unsigned W = REQ_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] i_level,
    output logic [W-1:0] o_rise_c
);

    logic [W-1:0] r_hist;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hist <= '1;
        end else begin
            r_hist <= i_level;
        end
    end

    assign o_rise_c = i_level & ~r_hist;

endmodule

// File: rtl/elevator_management_tx.sv
// Panel-to-elevator command transmitter: latches button requests, arbitrates
// by priority and emits one-cycle codes separated by a programmable idle gap.
module elevator_management_tx
    import elevator_mgmt_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        btn_floor,
    input  logic              btn_stop,
    input  logic              btn_hold,
    input  logic              btn_resume,
    output logic [3:0]        BCD_management,
    output logic              busy,
    output logic [5:0]        pending,
    output logic [CNT_W-1:0]  merged_cnt
);

    localparam int unsigned SUM_W = CNT_W + 3;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
    logic                r_busy;
    logic [REQ_W-1:0]    r_pending;
    logic [REQ_W-1:0]    w_pending_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [REQ_W-1:0]    w_btn;
    logic [REQ_W-1:0]    w_fire;
    logic [REQ_W-1:0]    w_grant;
    logic [REQ_W-1:0]    w_clear;
    logic [REQ_W-1:0]    w_merge;
    logic [SUM_W-1:0]    w_merge_n;
    logic [SUM_W-1:0]    w_cnt_sum;
    logic                w_arb;

    assign w_btn = {btn_resume, btn_stop, btn_hold, btn_floor};

    mgmt_edge_detect #(.W(REQ_W)) u_edge (
        .CLK      (CLK),
        .RST      (RST),
        .i_level  (w_btn),
        .o_rise_c (w_fire)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_gap     <= '0;
            r_code    <= CODE_NOP;
            r_busy    <= 1'b0;
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap     <= w_gap_nxt;
            r_code    <= w_code_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_pending <= w_pending_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // The last GAP cycle arbitrates like IDLE so back-to-back codes are
    // separated by exactly GAP_CYCLES idle cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_code_nxt  = CODE_NOP;
        w_grant     = '0;
        w_clear     = '0;
        w_arb       = 1'b0;
        case (r_state)
            IDLE: begin
                w_arb = 1'b1;
            end
            SEND: begin
                w_state_nxt = GAP;
                w_gap_nxt   = GAP_W'(GAP_CYCLES);
            end
            GAP: begin
                if (r_gap <= GAP_W'(1)) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = IDLE;
                    w_arb       = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gap_nxt   = '0;
            end
        endcase
        if (w_arb && (r_pending != '0)) begin
            w_grant     = pick_grant(r_pending);
            w_state_nxt = SEND;
            w_code_nxt  = grant_code(w_grant);
            w_clear     = w_grant;
            if (w_grant[IDX_STOP]) begin
                w_clear = w_clear | STOP_FLUSH_MASK;
            end
        end
    end

    // Fresh presses win over the clear; only presses onto a surviving bit merge.
    always_comb begin
        w_pending_nxt = (r_pending & ~w_clear) | w_fire;
        w_merge       = w_fire & r_pending & ~w_clear;
        w_merge_n     = '0;
        for (int unsigned i = 0; i < REQ_W; i++) begin
            w_merge_n = w_merge_n + SUM_W'(w_merge[i]);
        end
        w_cnt_sum = SUM_W'(r_cnt) + w_merge_n;
        if (w_cnt_sum[SUM_W-1:CNT_W] != '0) begin
            w_cnt_nxt = '1;
        end else begin
            w_cnt_nxt = w_cnt_sum[CNT_W-1:0];
        end
    end

    assign BCD_management = r_code;
    assign busy           = r_busy;
    assign pending        = r_pending;
    assign merged_cnt     = r_cnt;

endmodule

// File: tb/tb_elevator_management_tx.sv
// Scoreboarded bench: two transmitter instances (1-cycle gap / 8-bit counter and
// 3-cycle gap / 2-bit counter) checked against expected code streams.
module tb_elevator_management_tx;

    logic       CLK;
    logic       RST;
    logic [2:0] f1, f3;
    logic       s1, h1, r1, s3, h3, r3;
    logic [3:0] c1, c3;
    logic       b1, b3;
    logic [5:0] p1, p3;
    logic [7:0] m1;
    logic [1:0] m3;

    int errors = 0;
    int checks = 0;
    logic [3:0] q1[$];
    logic [3:0] q3[$];

    elevator_management_tx #(.GAP_CYCLES(1), .CNT_W(8)) u_dut1 (
        .CLK(CLK), .RST(RST), .btn_floor(f1), .btn_stop(s1), .btn_hold(h1),
        .btn_resume(r1), .BCD_management(c1), .busy(b1), .pending(p1), .merged_cnt(m1)
    );

    elevator_management_tx #(.GAP_CYCLES(3), .CNT_W(2)) u_dut3 (
        .CLK(CLK), .RST(RST), .btn_floor(f3), .btn_stop(s3), .btn_hold(h3),
        .btn_resume(r3), .BCD_management(c3), .busy(b3), .pending(p3), .merged_cnt(m3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard monitors: every non-NOP code must match the next expected one.
    always @(negedge CLK) begin
        logic [3:0] exp;
        if (c1 !== 4'b0000) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_code got=%b exp=none t=%0t", c1, $time);
            end else begin
                exp = q1.pop_front();
                if (c1 !== exp) begin
                    errors++;
                    $display("FAIL dut1_code got=%b exp=%b t=%0t", c1, exp, $time);
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic [3:0] exp;
        if (c3 !== 4'b0000) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL dut3_unexpected_code got=%b exp=none t=%0t", c3, $time);
            end else begin
                exp = q3.pop_front();
                if (c3 !== exp) begin
                    errors++;
                    $display("FAIL dut3_code got=%b exp=%b t=%0t", c3, exp, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        f1 = 3'b000; s1 = 1'b0; h1 = 1'b0; r1 = 1'b0;
        f3 = 3'b000; s3 = 1'b0; h3 = 1'b0; r3 = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        clear_inputs();
        q1.delete();
        q3.delete();
        repeat (2) tick();
        RST = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (q1.size() != 0 || q3.size() != 0); i++) begin
            tick();
        end
        repeat (2) tick();
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left1=%0d left3=%0d exp=0", q1.size(), q3.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        clear_inputs();
        f1 = 3'b001;
        f3 = 3'b001;
        repeat (2) tick();
        checks++;
        if ({c1, b1, p1, m1} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%b/%h exp=0", c1, b1, p1, m1);
        end
        RST = 1'b1;
        repeat (5) tick();
        checks++;
        if (p1 !== 6'd0 || p3 !== 6'd0) begin
            errors++;
            $display("FAIL held_through_reset_pending got=%b/%b exp=0", p1, p3);
        end
        checks++;
        if (m1 !== 8'd0 || m3 !== 2'd0) begin
            errors++;
            $display("FAIL held_through_reset_merged got=%h/%h exp=0", m1, m3);
        end
        f1 = 3'b000;
        f3 = 3'b000;
        repeat (4) tick();
        checks++;
        if (p1 !== 6'd0 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL held_release_idle got=%b/%b exp=0", p1, b1);
        end
    endtask

    task automatic test_single_floor();
        do_reset();
        q1.push_back(4'b0010);
        f1 = 3'b010;
        tick();
        f1 = 3'b000;
        checks++;
        if (p1 !== 6'b000010 || c1 !== 4'b0000 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL single_after_k got=%b/%b/%b exp=000010/0000/0", p1, c1, b1);
        end
        tick();
        checks++;
        if (c1 !== 4'b0010 || b1 !== 1'b1 || p1 !== 6'd0) begin
            errors++;
            $display("FAIL single_send got=%b/%b/%b exp=0010/1/000000", c1, b1, p1);
        end
        tick();
        checks++;
        if (c1 !== 4'b0000 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL single_gap got=%b/%b exp=0000/1", c1, b1);
        end
        tick();
        checks++;
        if (c1 !== 4'b0000 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got=%b/%b exp=0000/0", c1, b1);
        end
        wait_drain(10);
    endtask

    task automatic test_stop_flush();
        do_reset();
        q1.push_back(4'b1011);
        s1 = 1'b1; f1 = 3'b001; h1 = 1'b1;
        tick();
        s1 = 1'b0; f1 = 3'b000; h1 = 1'b0;
        checks++;
        if (p1 !== 6'b011001) begin
            errors++;
            $display("FAIL flush_pending_set got=%b exp=011001", p1);
        end
        tick();
        checks++;
        if (c1 !== 4'b1011 || p1 !== 6'd0) begin
            errors++;
            $display("FAIL flush_send got=%b/%b exp=1011/000000", c1, p1);
        end
        repeat (6) tick();
        checks++;
        if (p1 !== 6'd0 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL flush_after got=%b/%b exp=000000/0", p1, b1);
        end
        wait_drain(10);
    endtask

    task automatic test_merge();
        do_reset();
        q3.push_back(4'b1101);
        q3.push_back(4'b0011);
        r3 = 1'b1; f3 = 3'b100;
        tick();
        r3 = 1'b0; f3 = 3'b000;
        checks++;
        if (p3 !== 6'b100100) begin
            errors++;
            $display("FAIL merge_pending got=%b exp=100100", p3);
        end
        tick();
        checks++;
        if (c3 !== 4'b1101) begin
            errors++;
            $display("FAIL merge_resume got=%b exp=1101", c3);
        end
        f3 = 3'b100;
        tick();
        f3 = 3'b000;
        checks++;
        if (m3 !== 2'd1) begin
            errors++;
            $display("FAIL merge_cnt1 got=%0d exp=1", m3);
        end
        tick();
        checks++;
        if (c3 !== 4'b0000 || b3 !== 1'b1) begin
            errors++;
            $display("FAIL merge_gap got=%b/%b exp=0000/1", c3, b3);
        end
        f3 = 3'b100;
        tick();
        f3 = 3'b000;
        checks++;
        if (m3 !== 2'd2) begin
            errors++;
            $display("FAIL merge_cnt2 got=%0d exp=2", m3);
        end
        tick();
        checks++;
        if (c3 !== 4'b0011 || p3 !== 6'd0 || m3 !== 2'd2) begin
            errors++;
            $display("FAIL merge_floor3 got=%b/%b/%0d exp=0011/000000/2", c3, p3, m3);
        end
        wait_drain(20);
    endtask

    task automatic test_gap3();
        do_reset();
        q3.push_back(4'b0001);
        q3.push_back(4'b0010);
        f3 = 3'b011;
        tick();
        f3 = 3'b000;
        tick();
        checks++;
        if (c3 !== 4'b0001) begin
            errors++;
            $display("FAIL gap3_first got=%b exp=0001", c3);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (c3 !== 4'b0000 || b3 !== 1'b1) begin
                errors++;
                $display("FAIL gap3_idle%0d got=%b/%b exp=0000/1", i, c3, b3);
            end
        end
        tick();
        checks++;
        if (c3 !== 4'b0010) begin
            errors++;
            $display("FAIL gap3_second got=%b exp=0010", c3);
        end
        tick();
        checks++;
        if (c3 !== 4'b0000) begin
            errors++;
            $display("FAIL gap3_after got=%b exp=0000", c3);
        end
        wait_drain(20);
    endtask

    task automatic test_saturate();
        do_reset();
        q3.push_back(4'b1100);
        q3.push_back(4'b1100);
        q3.push_back(4'b0001);
        q3.push_back(4'b0010);
        q3.push_back(4'b0011);
        f3 = 3'b111; h3 = 1'b1;
        tick();
        f3 = 3'b000; h3 = 1'b0;
        checks++;
        if (p3 !== 6'b001111 || m3 !== 2'd0) begin
            errors++;
            $display("FAIL sat_initial got=%b/%0d exp=001111/0", p3, m3);
        end
        tick();
        f3 = 3'b111; h3 = 1'b1;
        tick();
        f3 = 3'b000; h3 = 1'b0;
        checks++;
        if (m3 !== 2'd3 || p3 !== 6'b001111) begin
            errors++;
            $display("FAIL sat_multi_merge got=%0d/%b exp=3/001111", m3, p3);
        end
        tick();
        f3 = 3'b110;
        tick();
        f3 = 3'b000;
        checks++;
        if (m3 !== 2'd3) begin
            errors++;
            $display("FAIL sat_hold got=%0d exp=3", m3);
        end
        wait_drain(40);
    endtask

    task automatic test_repress_at_clear();
        do_reset();
        q1.push_back(4'b1100);
        q1.push_back(4'b0001);
        q1.push_back(4'b0001);
        h1 = 1'b1; f1 = 3'b001;
        tick();
        h1 = 1'b0; f1 = 3'b000;
        tick();
        tick();
        f1 = 3'b001;
        tick();
        f1 = 3'b000;
        checks++;
        if (c1 !== 4'b0001 || p1 !== 6'b000001 || m1 !== 8'd0) begin
            errors++;
            $display("FAIL repress_clear got=%b/%b/%0d exp=0001/000001/0", c1, p1, m1);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        r1 = 1'b1; f1 = 3'b010;
        tick();
        r1 = 1'b0; f1 = 3'b000;
        tick();
        checks++;
        if (c1 !== 4'b1101 || p1 !== 6'b000010) begin
            errors++;
            $display("FAIL midsend_before got=%b/%b exp=1101/000010", c1, p1);
        end
        #1;
        RST = 1'b0;
        #1;
        checks++;
        if (c1 !== 4'b0000 || b1 !== 1'b0 || p1 !== 6'd0) begin
            errors++;
            $display("FAIL midsend_async got=%b/%b/%b exp=0000/0/000000", c1, b1, p1);
        end
        tick();
        RST = 1'b1;
        repeat (10) tick();
        checks++;
        if (p1 !== 6'd0 || b1 !== 1'b0 || q1.size() != 0) begin
            errors++;
            $display("FAIL midsend_after got=%b/%b/%0d exp=000000/0/0", p1, b1, q1.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        clear_inputs();
        test_reset();
        test_single_floor();
        test_stop_flush();
        test_merge();
        test_gap3();
        test_saturate();
        test_repress_at_clear();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
